// File: rtl/uart_cmd_host_pkg.sv
// -----------------------------------------------------------------------------
// uart_cmd_host_pkg
// Shared definitions for the host-side UART command initiator.
//   - cmd_op_e  : command type carried on cmd_op
//   - state_e   : controller states (IDLE, SEND, WAIT_RSP, DONE)
//   - OPC_*     : first byte of each frame, tells the far end what follows
//   - LEN_*     : number of bytes in each frame, opcode byte included
//   - frame_len / expects_rsp : per-command frame shape helpers
// -----------------------------------------------------------------------------
package uart_cmd_host_pkg;

  typedef enum logic [1:0] {
    OP_RF_WR   = 2'b00,
    OP_RF_RD   = 2'b01,
    OP_ALU_OP  = 2'b10,
    OP_ALU_NOP = 2'b11
  } cmd_op_e;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND     = 2'd1,
    WAIT_RSP = 2'd2,
    DONE     = 2'd3
  } state_e;

  localparam logic [7:0] OPC_RF_WR   = 8'hAA;
  localparam logic [7:0] OPC_RF_RD   = 8'hBB;
  localparam logic [7:0] OPC_ALU_OP  = 8'hCC;
  localparam logic [7:0] OPC_ALU_NOP = 8'hDD;

  localparam logic [2:0] LEN_RF_WR   = 3'd3;
  localparam logic [2:0] LEN_RF_RD   = 3'd2;
  localparam logic [2:0] LEN_ALU_OP  = 3'd4;
  localparam logic [2:0] LEN_ALU_NOP = 3'd2;

  function automatic logic [2:0] frame_len(input cmd_op_e op);
    logic [2:0] len;
    case (op)
      OP_RF_WR:   len = LEN_RF_WR;
      OP_RF_RD:   len = LEN_RF_RD;
      OP_ALU_OP:  len = LEN_ALU_OP;
      default:    len = LEN_ALU_NOP;
    endcase
    return len;
  endfunction

  // Register writes are fire-and-forget; every other command gets one byte back.
  function automatic logic expects_rsp(input cmd_op_e op);
    return (op != OP_RF_WR);
  endfunction

endpackage

// File: rtl/uart_cmd_host_rsp_timer.sv
// -----------------------------------------------------------------------------
// rsp_timer
// Loadable up-counter used to bound how long a block waits for a response.
//   clk, rst_n  : clock, asynchronous active-low reset
//   clr         : synchronous clear to zero (highest priority)
//   load        : synchronous load of load_val
//   load_val    : value taken on load
//   en          : count up by one
//   tc_val      : terminal count value
//   tc          : high while the count equals tc_val
// -----------------------------------------------------------------------------
module rsp_timer #(
  parameter int TMO_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [TMO_W-1:0] load_val,
  input  logic             en,
  input  logic [TMO_W-1:0] tc_val,
  output logic             tc
);

  logic [TMO_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (load) begin
      count_d = load_val;
    end else if (en) begin
      count_d = count_q + TMO_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc = (count_q == tc_val);

endmodule

// File: rtl/uart_cmd_host.sv
// -----------------------------------------------------------------------------
// uart_cmd_host
// Host-side command initiator. Takes one command per cmd_valid/cmd_ready
// handshake, sends it as an opcode-led byte frame on the TX byte interface,
// waits (bounded) for the single response byte on the RX byte interface and
// reports the outcome as a one-cycle rsp_valid pulse.
//   CLK, RST        : clock, asynchronous active-low reset
//   cmd_*           : command request / fields, cmd_ready high only in IDLE
//   tx_data/valid   : frame byte towards UART TX, tx_ready is its backpressure
//   rx_data/valid   : received byte pulse, rx_err flags a parity/stop error
//   rsp_*           : completion pulse with data, timeout and error flags
//   busy            : high whenever a command is in flight
// -----------------------------------------------------------------------------
module uart_cmd_host
  import uart_cmd_host_pkg::*;
#(
  parameter int               DW      = 8,
  parameter int               FUN_W   = 4,
  parameter int               ADDR_W  = 4,
  parameter int               TMO_W   = 16,
  parameter logic [TMO_W-1:0] TMO_CYC = 16'd5000
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DW-1:0]     cmd_wdata,
  input  logic [DW-1:0]     cmd_a,
  input  logic [DW-1:0]     cmd_b,
  input  logic [FUN_W-1:0]  cmd_fun,
  output logic [DW-1:0]     tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [DW-1:0]     rx_data,
  input  logic              rx_valid,
  input  logic              rx_err,
  output logic              rsp_valid,
  output logic [DW-1:0]     rsp_data,
  output logic              rsp_timeout,
  output logic              rsp_err,
  output logic              busy
);

  // The timer flags the last waiting cycle, so the timeout lands exactly
  // TMO_CYC cycles after entering WAIT_RSP.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_CYC - TMO_W'(1);

  state_e              state_q, state_d;
  cmd_op_e             op_q, op_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DW-1:0]       wdata_q, wdata_d;
  logic [DW-1:0]       a_q, a_d;
  logic [DW-1:0]       b_q, b_d;
  logic [FUN_W-1:0]    fun_q, fun_d;
  logic [1:0]          idx_q, idx_d;
  logic [DW-1:0]       rsp_data_q, rsp_data_d;
  logic                rsp_timeout_q, rsp_timeout_d;
  logic                rsp_err_q, rsp_err_d;

  logic                tmr_clr;
  logic                tmr_en;
  logic                tmr_tc;
  logic                last_byte;
  logic [DW-1:0]       byte_sel;

  rsp_timer #(
    .TMO_W(TMO_W)
  ) u_rsp_timer (
    .clk      (CLK),
    .rst_n    (RST),
    .clr      (tmr_clr),
    .load     (1'b0),
    .load_val ('0),
    .en       (tmr_en),
    .tc_val   (TMO_LAST),
    .tc       (tmr_tc)
  );

  // Frame byte mux: opcode first, then the fields in protocol order with
  // addr and fun zero-extended to a full byte.
  always_comb begin
    byte_sel = '0;
    case (op_q)
      OP_RF_WR: begin
        case (idx_q)
          2'd0:    byte_sel = DW'(OPC_RF_WR);
          2'd1:    byte_sel = DW'(addr_q);
          2'd2:    byte_sel = wdata_q;
          default: byte_sel = '0;
        endcase
      end
      OP_RF_RD: begin
        case (idx_q)
          2'd0:    byte_sel = DW'(OPC_RF_RD);
          2'd1:    byte_sel = DW'(addr_q);
          default: byte_sel = '0;
        endcase
      end
      OP_ALU_OP: begin
        case (idx_q)
          2'd0:    byte_sel = DW'(OPC_ALU_OP);
          2'd1:    byte_sel = a_q;
          2'd2:    byte_sel = b_q;
          default: byte_sel = DW'(fun_q);
        endcase
      end
      default: begin
        case (idx_q)
          2'd0:    byte_sel = DW'(OPC_ALU_NOP);
          2'd1:    byte_sel = DW'(fun_q);
          default: byte_sel = '0;
        endcase
      end
    endcase
  end

  assign last_byte = ({1'b0, idx_q} == (frame_len(op_q) - 3'd1));

  // Next-state logic. The timer is held clear outside WAIT_RSP so it always
  // starts from zero on entry. A response byte takes priority over the
  // terminal count when both happen in the same cycle.
  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    a_d           = a_q;
    b_d           = b_q;
    fun_d         = fun_q;
    idx_d         = idx_q;
    rsp_data_d    = rsp_data_q;
    rsp_timeout_d = rsp_timeout_q;
    rsp_err_d     = rsp_err_q;
    tmr_clr       = 1'b1;
    tmr_en        = 1'b0;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          op_d          = cmd_op_e'(cmd_op);
          addr_d        = cmd_addr;
          wdata_d       = cmd_wdata;
          a_d           = cmd_a;
          b_d           = cmd_b;
          fun_d         = cmd_fun;
          idx_d         = 2'd0;
          rsp_data_d    = '0;
          rsp_timeout_d = 1'b0;
          rsp_err_d     = 1'b0;
          state_d       = SEND;
        end
      end
      SEND: begin
        if (tx_ready) begin
          if (last_byte) begin
            idx_d   = 2'd0;
            state_d = expects_rsp(op_q) ? WAIT_RSP : DONE;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      WAIT_RSP: begin
        tmr_clr = 1'b0;
        tmr_en  = 1'b1;
        if (rx_valid) begin
          rsp_data_d = rx_data;
          rsp_err_d  = rx_err;
          state_d    = DONE;
        end else if (tmr_tc) begin
          rsp_data_d    = '0;
          rsp_timeout_d = 1'b1;
          state_d       = DONE;
        end
      end
      default: begin
        rsp_timeout_d = 1'b0;
        rsp_err_d     = 1'b0;
        state_d       = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q       <= IDLE;
      op_q          <= OP_RF_WR;
      addr_q        <= '0;
      wdata_q       <= '0;
      a_q           <= '0;
      b_q           <= '0;
      fun_q         <= '0;
      idx_q         <= 2'd0;
      rsp_data_q    <= '0;
      rsp_timeout_q <= 1'b0;
      rsp_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      a_q           <= a_d;
      b_q           <= b_d;
      fun_q         <= fun_d;
      idx_q         <= idx_d;
      rsp_data_q    <= rsp_data_d;
      rsp_timeout_q <= rsp_timeout_d;
      rsp_err_q     <= rsp_err_d;
    end
  end

  // Outputs decode straight from the state register, so an async reset
  // drops tx_valid immediately.
  assign tx_valid    = (state_q == SEND);
  assign tx_data     = (state_q == SEND) ? byte_sel : '0;
  assign rsp_valid   = (state_q == DONE);
  assign rsp_data    = rsp_data_q;
  assign rsp_timeout = rsp_timeout_q;
  assign rsp_err     = rsp_err_q;
  assign cmd_ready   = (state_q == IDLE);
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_uart_cmd_host.sv
// -----------------------------------------------------------------------------
// tb_uart_cmd_host
// Self-checking bench for uart_cmd_host. Each command is predicted by a small
// reference model (frame byte list, handshake cycles derived from the tx_ready
// pattern, and the response outcome) and compared with what the bench observes.
// Cycle numbers count from the command-capture edge: cycle 1 is the first
// cycle after cmd_valid&&cmd_ready was sampled.
// -----------------------------------------------------------------------------
module tb_uart_cmd_host;

  localparam int TMO = 16;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [3:0] cmd_addr = '0;
  logic [7:0] cmd_wdata = '0;
  logic [7:0] cmd_a = '0;
  logic [7:0] cmd_b = '0;
  logic [3:0] cmd_fun = '0;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b0;
  logic [7:0] rx_data = '0;
  logic       rx_valid = 1'b0;
  logic       rx_err = 1'b0;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_timeout;
  logic       rsp_err;
  logic       busy;

  int checks = 0;
  int errors = 0;

  bit         ready_pat [300];

  logic [7:0] obs_bytes [$];
  int         obs_hs [$];
  logic [7:0] obs_rsp_data;
  logic       obs_tmo;
  logic       obs_err;
  int         obs_rsp_cyc;
  int         obs_hold_err;
  int         obs_ready_busy;
  logic       obs_pulse_again;
  logic [1:0] obs_flags_after;
  logic       obs_ready_after;
  bit         obs_hung;

  logic [7:0] exp_bytes [$];
  int         exp_hs [$];
  logic [7:0] exp_rsp_data;
  logic       exp_tmo;
  logic       exp_err;
  int         exp_rsp_cyc;

  uart_cmd_host #(
    .DW(8), .FUN_W(4), .ADDR_W(4), .TMO_W(16), .TMO_CYC(16'd16)
  ) dut (
    .CLK(CLK), .RST(RST),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_a(cmd_a),
    .cmd_b(cmd_b), .cmd_fun(cmd_fun),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_err(rx_err),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_timeout(rsp_timeout),
    .rsp_err(rsp_err), .busy(busy)
  );

  always #5 CLK = ~CLK;

  // Reference model: frame contents from the protocol table, handshake cycles
  // from the ready pattern, response outcome from the delay relative to the
  // first waiting cycle (the cycle after the last handshake).
  function automatic void model_cmd(input logic [1:0] op, input logic [3:0] addr,
                                    input logic [7:0] wdata, input logic [7:0] a,
                                    input logic [7:0] b, input logic [3:0] fun,
                                    input int rx_delay, input logic [7:0] rx_byte,
                                    input logic rx_e);
    int c;
    int w;
    exp_bytes.delete();
    exp_hs.delete();
    case (op)
      2'b00: begin exp_bytes.push_back(8'hAA); exp_bytes.push_back({4'h0, addr}); exp_bytes.push_back(wdata); end
      2'b01: begin exp_bytes.push_back(8'hBB); exp_bytes.push_back({4'h0, addr}); end
      2'b10: begin exp_bytes.push_back(8'hCC); exp_bytes.push_back(a); exp_bytes.push_back(b); exp_bytes.push_back({4'h0, fun}); end
      default: begin exp_bytes.push_back(8'hDD); exp_bytes.push_back({4'h0, fun}); end
    endcase
    c = 1;
    for (int i = 0; i < exp_bytes.size(); i++) begin
      while (c < 299 && !ready_pat[c]) c++;
      exp_hs.push_back(c);
      c++;
    end
    w = exp_hs[exp_hs.size()-1] + 1;
    if (op == 2'b00) begin
      exp_rsp_data = 8'h00; exp_tmo = 1'b0; exp_err = 1'b0; exp_rsp_cyc = w;
    end else if (rx_delay >= 0 && rx_delay < TMO) begin
      exp_rsp_data = rx_byte; exp_tmo = 1'b0; exp_err = rx_e; exp_rsp_cyc = w + rx_delay + 1;
    end else begin
      exp_rsp_data = 8'h00; exp_tmo = 1'b1; exp_err = 1'b0; exp_rsp_cyc = w + TMO;
    end
  endfunction

  // Drives one command and records what the DUT did. rx_delay counts cycles
  // from the first observed waiting cycle; -1 means no response is sent.
  task automatic do_cmd(input logic [1:0] op, input logic [3:0] addr,
                        input logic [7:0] wdata, input logic [7:0] a,
                        input logic [7:0] b, input logic [3:0] fun,
                        input int rx_delay, input logic [7:0] rx_byte,
                        input logic rx_e, input bit stray, input bit keep_valid);
    int guard;
    int cyc;
    int w_cyc;
    bit got;
    bit prev_stall;
    logic [7:0] prev_data;
    obs_bytes.delete();
    obs_hs.delete();
    obs_hold_err = 0; obs_ready_busy = 0; obs_hung = 0;
    obs_rsp_data = 8'h00; obs_tmo = 1'b0; obs_err = 1'b0; obs_rsp_cyc = -1;
    guard = 0;
    @(negedge CLK);
    while (cmd_ready !== 1'b1 && guard < 100) begin
      @(negedge CLK);
      guard++;
    end
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_wdata = wdata;
    cmd_a = a; cmd_b = b; cmd_fun = fun; tx_ready = 1'b0; rx_valid = 1'b0;
    cyc = 0; w_cyc = -1; got = 0; prev_stall = 0; prev_data = 8'h00;
    while (!got && cyc < 299) begin
      @(negedge CLK);
      cyc++;
      rx_valid = 1'b0; rx_err = 1'($urandom); rx_data = 8'($urandom);
      if (keep_valid) begin
        cmd_op = 2'($urandom); cmd_addr = 4'($urandom); cmd_wdata = 8'($urandom);
        cmd_a = 8'($urandom); cmd_b = 8'($urandom); cmd_fun = 4'($urandom);
      end else begin
        cmd_valid = 1'b0;
      end
      if (prev_stall && (tx_valid !== 1'b1 || tx_data !== prev_data)) obs_hold_err++;
      if (rsp_valid === 1'b1) begin
        got = 1; obs_rsp_data = rsp_data; obs_tmo = rsp_timeout; obs_err = rsp_err;
        obs_rsp_cyc = cyc; cmd_valid = 1'b0; tx_ready = 1'b0;
      end else begin
        if (cmd_ready === 1'b1) obs_ready_busy++;
        tx_ready = ready_pat[cyc];
        if (tx_valid === 1'b1 && tx_ready) begin
          obs_bytes.push_back(tx_data);
          obs_hs.push_back(cyc);
        end
        prev_stall = (tx_valid === 1'b1) && !tx_ready;
        prev_data = tx_data;
        if (busy === 1'b1 && tx_valid !== 1'b1 && w_cyc < 0) w_cyc = cyc;
        if (w_cyc >= 0 && rx_delay >= 0 && cyc == w_cyc + rx_delay) begin
          rx_valid = 1'b1; rx_data = rx_byte; rx_err = rx_e;
        end
        if (stray && cyc == 1) rx_valid = 1'b1;
      end
    end
    if (!got) begin
      obs_hung = 1; cmd_valid = 1'b0; tx_ready = 1'b0;
    end
    @(negedge CLK);
    rx_valid = 1'b0;
    obs_pulse_again = rsp_valid;
    obs_flags_after = {rsp_timeout, rsp_err};
    obs_ready_after = cmd_ready;
  endtask

  task automatic fill_ready(input int mode);
    for (int k = 0; k < 300; k++) begin
      if (mode == 0) ready_pat[k] = 1'b1;
      else if (mode == 1) ready_pat[k] = (k % 2 == 1);
      else ready_pat[k] = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic test_reset;
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset tx_valid: got %b expected 0", tx_valid); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("[TB] FAIL reset tx_data: got %h expected 00", tx_data); end
    checks++; if ({rsp_valid, rsp_timeout, rsp_err, busy} !== 4'b0000) begin errors++; $display("[TB] FAIL reset flags: got %b expected 0000", {rsp_valid, rsp_timeout, rsp_err, busy}); end
    checks++; if (rsp_data !== 8'h00) begin errors++; $display("[TB] FAIL reset rsp_data: got %h expected 00", rsp_data); end
    RST = 1'b1;
    @(negedge CLK);
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset cmd_ready: got %b expected 1", cmd_ready); end
  endtask

  task automatic test_rf_wr;
    fill_ready(0);
    model_cmd(2'b00, 4'h3, 8'h5A, 8'h00, 8'h00, 4'h0, -1, 8'h00, 1'b0);
    do_cmd(2'b00, 4'h3, 8'h5A, 8'h00, 8'h00, 4'h0, -1, 8'h00, 1'b0, 1'b0, 1'b0);
    checks++; if (obs_hung) begin errors++; $display("[TB] FAIL rf_wr completion: got none expected rsp_valid"); end
    checks++; if (obs_bytes != exp_bytes) begin errors++; $display("[TB] FAIL rf_wr bytes: got %p expected %p", obs_bytes, exp_bytes); end
    checks++; if (obs_hs != exp_hs) begin errors++; $display("[TB] FAIL rf_wr handshake cycles: got %p expected %p", obs_hs, exp_hs); end
    checks++; if (obs_rsp_cyc != exp_rsp_cyc) begin errors++; $display("[TB] FAIL rf_wr rsp cycle: got %0d expected %0d", obs_rsp_cyc, exp_rsp_cyc); end
    checks++; if ({obs_rsp_data, obs_tmo, obs_err} !== 10'h0) begin errors++; $display("[TB] FAIL rf_wr rsp: got %h/%b/%b expected 00/0/0", obs_rsp_data, obs_tmo, obs_err); end
    checks++; if (obs_pulse_again !== 1'b0 || obs_ready_after !== 1'b1) begin errors++; $display("[TB] FAIL rf_wr after pulse: got valid=%b ready=%b expected 0/1", obs_pulse_again, obs_ready_after); end
  endtask

  task automatic test_alu_toggle;
    fill_ready(1);
    model_cmd(2'b10, 4'h0, 8'h00, 8'h12, 8'h34, 4'h0, 2, 8'h46, 1'b0);
    do_cmd(2'b10, 4'h0, 8'h00, 8'h12, 8'h34, 4'h0, 2, 8'h46, 1'b0, 1'b0, 1'b0);
    checks++; if (obs_bytes != exp_bytes) begin errors++; $display("[TB] FAIL alu bytes: got %p expected %p", obs_bytes, exp_bytes); end
    checks++; if (obs_hs != exp_hs) begin errors++; $display("[TB] FAIL alu handshake cycles: got %p expected %p", obs_hs, exp_hs); end
    checks++; if (obs_hold_err != 0) begin errors++; $display("[TB] FAIL alu hold: got %0d unstable cycles expected 0", obs_hold_err); end
    checks++; if (obs_rsp_data !== 8'h46 || obs_rsp_cyc != exp_rsp_cyc) begin errors++; $display("[TB] FAIL alu rsp: got %h@%0d expected 46@%0d", obs_rsp_data, obs_rsp_cyc, exp_rsp_cyc); end
  endtask

  task automatic test_rd_timeout;
    fill_ready(0);
    model_cmd(2'b01, 4'h2, 8'h00, 8'h00, 8'h00, 4'h0, -1, 8'h00, 1'b0);
    do_cmd(2'b01, 4'h2, 8'h00, 8'h00, 8'h00, 4'h0, -1, 8'h00, 1'b0, 1'b0, 1'b0);
    checks++; if (obs_rsp_cyc != exp_rsp_cyc) begin errors++; $display("[TB] FAIL timeout cycle: got %0d expected %0d", obs_rsp_cyc, exp_rsp_cyc); end
    checks++; if ({obs_rsp_data, obs_tmo, obs_err} !== {8'h00, 1'b1, 1'b0}) begin errors++; $display("[TB] FAIL timeout rsp: got %h/%b/%b expected 00/1/0", obs_rsp_data, obs_tmo, obs_err); end
    checks++; if (obs_flags_after !== 2'b00) begin errors++; $display("[TB] FAIL timeout flags clear: got %b expected 00", obs_flags_after); end
  endtask

  task automatic test_nop_err;
    fill_ready(0);
    model_cmd(2'b11, 4'h0, 8'h00, 8'h00, 8'h00, 4'h1, 1, 8'hFF, 1'b1);
    do_cmd(2'b11, 4'h0, 8'h00, 8'h00, 8'h00, 4'h1, 1, 8'hFF, 1'b1, 1'b0, 1'b0);
    checks++; if (obs_bytes != exp_bytes) begin errors++; $display("[TB] FAIL nop bytes: got %p expected %p", obs_bytes, exp_bytes); end
    checks++; if ({obs_rsp_data, obs_tmo, obs_err} !== {8'hFF, 1'b0, 1'b1}) begin errors++; $display("[TB] FAIL nop err rsp: got %h/%b/%b expected ff/0/1", obs_rsp_data, obs_tmo, obs_err); end
  endtask

  task automatic test_stray_rx;
    fill_ready(0);
    model_cmd(2'b01, 4'h5, 8'h00, 8'h00, 8'h00, 4'h0, 3, 8'h77, 1'b0);
    do_cmd(2'b01, 4'h5, 8'h00, 8'h00, 8'h00, 4'h0, 3, 8'h77, 1'b0, 1'b1, 1'b0);
    checks++; if (obs_rsp_data !== 8'h77 || obs_rsp_cyc != exp_rsp_cyc) begin errors++; $display("[TB] FAIL stray rx: got %h@%0d expected 77@%0d", obs_rsp_data, obs_rsp_cyc, exp_rsp_cyc); end
  endtask

  task automatic test_tmo_terminal;
    logic [7:0] d;
    d = 8'($urandom);
    fill_ready(0);
    model_cmd(2'b10, 4'h0, 8'h00, 8'h01, 8'h02, 4'h3, TMO - 1, d, 1'b0);
    do_cmd(2'b10, 4'h0, 8'h00, 8'h01, 8'h02, 4'h3, TMO - 1, d, 1'b0, 1'b0, 1'b0);
    checks++; if ({obs_rsp_data, obs_tmo} !== {d, 1'b0} || obs_rsp_cyc != exp_rsp_cyc) begin errors++; $display("[TB] FAIL terminal-cycle rx: got %h/%b@%0d expected %h/0@%0d", obs_rsp_data, obs_tmo, obs_rsp_cyc, d, exp_rsp_cyc); end
  endtask

  task automatic test_back_to_back;
    fill_ready(0);
    for (int n = 0; n < 2; n++) begin
      model_cmd(2'b10, 4'h0, 8'h00, 8'hA0 + 8'(n), 8'h5B, 4'h7, 0, 8'h3C, 1'b0);
      do_cmd(2'b10, 4'h0, 8'h00, 8'hA0 + 8'(n), 8'h5B, 4'h7, 0, 8'h3C, 1'b0, 1'b0, 1'b1);
      checks++; if (obs_ready_busy != 0) begin errors++; $display("[TB] FAIL busy cmd_ready: got %0d ready cycles expected 0", obs_ready_busy); end
      checks++; if (obs_bytes != exp_bytes) begin errors++; $display("[TB] FAIL busy recapture bytes: got %p expected %p", obs_bytes, exp_bytes); end
    end
  endtask

  task automatic test_reset_mid_send;
    int pulses;
    fill_ready(0);
    @(negedge CLK);
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_a = 8'h21; cmd_b = 8'h43; cmd_fun = 4'h2; tx_ready = 1'b1;
    @(negedge CLK);
    cmd_valid = 1'b0;
    repeat (2) @(negedge CLK);
    checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h43) begin errors++; $display("[TB] FAIL mid-send byte2: got %b/%h expected 1/43", tx_valid, tx_data); end
    #2 RST = 1'b0;
    #1;
    checks++; if (tx_valid !== 1'b0 || tx_data !== 8'h00 || busy !== 1'b0) begin errors++; $display("[TB] FAIL async reset: got valid=%b data=%h busy=%b expected 0/00/0", tx_valid, tx_data, busy); end
    pulses = 0;
    repeat (3) begin
      @(negedge CLK);
      if (rsp_valid !== 1'b0) pulses++;
    end
    RST = 1'b1; tx_ready = 1'b0;
    repeat (2) begin
      @(negedge CLK);
      if (rsp_valid !== 1'b0) pulses++;
    end
    checks++; if (pulses != 0) begin errors++; $display("[TB] FAIL reset pulse: got %0d rsp_valid cycles expected 0", pulses); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL post-reset cmd_ready: got %b expected 1", cmd_ready); end
    model_cmd(2'b01, 4'h9, 8'h00, 8'h00, 8'h00, 4'h0, 4, 8'h5E, 1'b0);
    do_cmd(2'b01, 4'h9, 8'h00, 8'h00, 8'h00, 4'h0, 4, 8'h5E, 1'b0, 1'b0, 1'b0);
    checks++; if (obs_bytes != exp_bytes || obs_rsp_data !== 8'h5E || obs_rsp_cyc != exp_rsp_cyc) begin errors++; $display("[TB] FAIL post-reset rf_rd: got %p %h@%0d expected %p 5e@%0d", obs_bytes, obs_rsp_data, obs_rsp_cyc, exp_bytes, exp_rsp_cyc); end
  endtask

  task automatic test_random;
    logic [1:0] op;
    logic [3:0] addr, fun;
    logic [7:0] wdata, a, b, rb;
    logic       re;
    int         dly;
    bit         stray, keep;
    for (int n = 0; n < 40; n++) begin
      op = 2'($urandom); addr = 4'($urandom); fun = 4'($urandom);
      wdata = 8'($urandom); a = 8'($urandom); b = 8'($urandom);
      rb = 8'($urandom); re = 1'($urandom);
      dly = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, TMO + 2));
      stray = 1'($urandom); keep = 1'($urandom);
      fill_ready(2);
      model_cmd(op, addr, wdata, a, b, fun, dly, rb, re);
      do_cmd(op, addr, wdata, a, b, fun, dly, rb, re, stray, keep);
      checks++; if (obs_bytes != exp_bytes) begin errors++; $display("[TB] FAIL rand%0d bytes: got %p expected %p", n, obs_bytes, exp_bytes); end
      checks++; if (obs_hs != exp_hs) begin errors++; $display("[TB] FAIL rand%0d handshake cycles: got %p expected %p", n, obs_hs, exp_hs); end
      checks++; if (obs_rsp_cyc != exp_rsp_cyc) begin errors++; $display("[TB] FAIL rand%0d rsp cycle: got %0d expected %0d", n, obs_rsp_cyc, exp_rsp_cyc); end
      checks++; if ({obs_rsp_data, obs_tmo, obs_err} !== {exp_rsp_data, exp_tmo, exp_err}) begin errors++; $display("[TB] FAIL rand%0d rsp: got %h/%b/%b expected %h/%b/%b", n, obs_rsp_data, obs_tmo, obs_err, exp_rsp_data, exp_tmo, exp_err); end
      checks++; if (obs_hold_err != 0 || obs_ready_busy != 0) begin errors++; $display("[TB] FAIL rand%0d hold/ready: got %0d/%0d expected 0/0", n, obs_hold_err, obs_ready_busy); end
      checks++; if ({obs_pulse_again, obs_flags_after, obs_ready_after} !== 4'b0001) begin errors++; $display("[TB] FAIL rand%0d after pulse: got %b expected 0001", n, {obs_pulse_again, obs_flags_after, obs_ready_after}); end
    end
  endtask

  initial begin
    test_reset();
    test_rf_wr();
    test_alu_toggle();
    test_rd_timeout();
    test_nop_err();
    test_stray_rx();
    test_tmo_terminal();
    test_back_to_back();
    test_reset_mid_send();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
